move_ctrl: RTL and testbench
============================

MOVE_CTRL -- requirements
Module: move_ctrl

Interface
REQ-001: Parameter START_PLAYER, default 1'b0, SHALL set the player who moves first after reset (0 = X, 1 = O).
REQ-002: ph1  input  1  first phase of the two-phase non-overlapping clock.
REQ-003: ph2  input  1  second phase of the two-phase non-overlapping clock; one cycle is one ph1 period followed by one ph2 period.
REQ-004: reset  input  1  synchronous, active-low.
REQ-005: moveValid  input  1  player move request, held until accepted.
REQ-006: moveAddr  input  4  requested cell, 0-8, row-major.
REQ-007: moveReady  output  1  controller can accept a move this cycle.
REQ-008: gBoard  input  18  board from the memory array, 2 bits per cell, cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O.
REQ-009: wrEn  output  1  write strobe to the memory array.
REQ-010: addr  output  4  write cell index to the memory array.
REQ-011: cellState  output  2  value written to the memory array (01 X, 10 O).
REQ-012: turn  output  1  player to move (0 X, 1 O).
REQ-013: status  output  2  00 playing, 01 X wins, 10 O wins, 11 draw.
REQ-014: illegal  output  1  one-cycle pulse for a rejected move.

Function
REQ-015: All state SHALL be held in ph2-master/ph1-slave latch pairs, giving flip-flop behaviour with a one-cycle update.
REQ-016: The FSM SHALL have the states IDLE, CHECK, WRITE, EVAL and DONE.
REQ-017: moveReady SHALL be 1 only in IDLE; a move is accepted in cycle N when moveValid and moveReady are both 1, and moveAddr is captured at that point.
REQ-018: In CHECK (cycle N+1), a captured address greater than 8, or a cell that gBoard shows as non-empty, SHALL cause illegal=1 for that cycle and a return to IDLE, with turn and the move count unchanged.
REQ-019: A legal move SHALL enter WRITE at N+2 and drive wrEn=1 for exactly one cycle, with addr set to the captured address and cellState set to 01 when turn=0 or 10 when turn=1.
REQ-020: EVAL at N+3 SHALL evaluate the updated gBoard for the current player over all 8 lines (3 rows, 3 columns, 2 diagonals).
REQ-021: From EVAL, a winning line SHALL set status to 01 or 10 and enter DONE.
REQ-022: From EVAL with no winning line, a move count that has reached 9 SHALL set status=11 and enter DONE.
REQ-023: From EVAL with no winning line and a move count below 9, the FSM SHALL toggle turn and return to IDLE.
REQ-024: The move count SHALL be a 4-bit counter that increments once per WRITE and saturates at 9.
REQ-025: A win on the 9th move SHALL be reported as a win, not a draw.
REQ-026: DONE SHALL be terminal: moveReady=0, wrEn=0, status held, and moveValid ignored until reset.
REQ-027: In states other than IDLE, moveValid SHALL be ignored and moveAddr is don't-care.
REQ-028: wrEn SHALL never be 1 outside WRITE.

Reset
REQ-029: reset=0 sampled at any cycle SHALL force the next state to IDLE with turn=START_PLAYER, status=00, move count=0, wrEn=0, illegal=0 and moveReady=1 once reset=1.
REQ-030: While reset=0, wrEn SHALL be 0 combinationally, including a reset that arrives in WRITE, so no write reaches the array.
REQ-031: The memory array SHALL share the same reset, so the board is empty when IDLE is re-entered.

Structure
REQ-032: Package ttt_pkg SHALL hold the cell encodings (EMPTY, X, O), the status encodings, the FSM state enum, NCELLS=9 and the table of the 8 winning-line cell triples.
REQ-033: Sub-module win_check SHALL be purely combinational, taking gBoard and a 2-bit player code and returning a 1-bit win flag, and is the only sub-module.

Verification
REQ-034: The bench SHALL cover reset followed by moveValid=1 with moveAddr=4: wrEn=1, addr=4, cellState=01 at N+2; turn=1 at N+4.
REQ-035: The bench SHALL cover a move to occupied cell 4 after the previous scenario: illegal=1 at N+1, no wrEn, turn unchanged.
REQ-036: The bench SHALL cover moveAddr=9 and moveAddr=15: illegal pulse, no write.
REQ-037: The bench SHALL cover the sequence X0, O3, X1, O4, X2: status=01 after the 5th EVAL, moveReady=0 thereafter, and further moveValid pulses produce no wrEn.
REQ-038: The bench SHALL cover the sequence X0, O1, X2, O4, X3, O5, X7, O6, X8: status=11 and move count=9.
REQ-039: The bench SHALL cover reset=0 asserted during a WRITE cycle: wrEn=0 in that cycle, and status=00, turn=0, moveReady=1 on the next cycle with reset=1.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe move controller: cell and status
// codes, the controller state enum, the state-register bundle and the table
// of the eight winning lines.
package ttt_pkg;

  localparam int NCELLS = 9;

  // Cell contents as stored in the board memory
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  // Game status codes
  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_X_WIN   = 2'b01;
  localparam logic [1:0] ST_O_WIN   = 2'b10;
  localparam logic [1:0] ST_DRAW    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WRITE = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Everything the controller remembers from one cycle to the next
  typedef struct packed {
    state_e     state;
    logic       turn;
    logic [1:0] status;
    logic [3:0] cnt;
    logic [3:0] cap_addr;
  } ctrl_t;

  // Winning lines as cell-index triples; entry 0 is the leftmost group
  localparam logic [0:7][0:2][3:0] WIN_LINES = {
    4'd0, 4'd1, 4'd2,   // top row
    4'd3, 4'd4, 4'd5,   // middle row
    4'd6, 4'd7, 4'd8,   // bottom row
    4'd0, 4'd3, 4'd6,   // left column
    4'd1, 4'd4, 4'd7,   // middle column
    4'd2, 4'd5, 4'd8,   // right column
    4'd0, 4'd4, 4'd8,   // main diagonal
    4'd2, 4'd4, 4'd6    // anti diagonal
  };

  // Cell code a player writes: X for turn 0, O for turn 1
  function automatic logic [1:0] player_code(input logic t);
    return t ? CELL_O : CELL_X;
  endfunction

  // Contents of one cell; indices past the board read as empty
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
    logic [4:0] base;
    base = {idx, 1'b0};
    if (idx < 4'd9) begin
      return board[base +: 2];
    end else begin
      return CELL_EMPTY;
    end
  endfunction

endpackage

// File: rtl/move_ctrl_win_check.sv
// Purely combinational three-in-a-row detector for one player.
module win_check
  import ttt_pkg::*;
(
  input  logic [17:0] gBoard,
  input  logic [1:0]  player,
  output logic        win
);

  // OR together every line whose three cells all hold the player's code
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      win = win | ((cell_at(gBoard, WIN_LINES[i][0]) == player) &
                   (cell_at(gBoard, WIN_LINES[i][1]) == player) &
                   (cell_at(gBoard, WIN_LINES[i][2]) == player));
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// Tic-tac-toe move controller: accepts a move, rejects bad cells, writes the
// board memory, then scores the board for a win or a draw. State lives in a
// ph2 master stage feeding a ph1-transparent slave latch, so every update
// lands one two-phase cycle later.
module move_ctrl
  import ttt_pkg::*;
#(
  parameter logic START_PLAYER = 1'b0
) (
  input  logic        ph1,
  input  logic        ph2,
  input  logic        reset,
  input  logic        moveValid,
  input  logic [3:0]  moveAddr,
  output logic        moveReady,
  input  logic [17:0] gBoard,
  output logic        wrEn,
  output logic [3:0]  addr,
  output logic [1:0]  cellState,
  output logic        turn,
  output logic [1:0]  status,
  output logic        illegal
);

  ctrl_t ctl_next_s;
  ctrl_t ctl_mst_r;
  ctrl_t ctl_r;
  logic  bad_s;
  logic  win_s;

  win_check u_win (
    .gBoard (gBoard),
    .player (player_code(ctl_r.turn)),
    .win    (win_s)
  );

  assign bad_s = (ctl_r.cap_addr > 4'd8) | (cell_at(gBoard, ctl_r.cap_addr) != CELL_EMPTY);

  // Next-state and next-data decision for the whole controller
  always_comb begin
    ctl_next_s = ctl_r;
    if (!reset) begin
      ctl_next_s.state    = S_IDLE;
      ctl_next_s.turn     = START_PLAYER;
      ctl_next_s.status   = ST_PLAYING;
      ctl_next_s.cnt      = 4'd0;
      ctl_next_s.cap_addr = 4'd0;
    end else begin
      case (ctl_r.state)
        S_IDLE: begin
          if (moveValid) begin
            ctl_next_s.state    = S_CHECK;
            ctl_next_s.cap_addr = moveAddr;
          end else begin
            ctl_next_s.state = S_IDLE;
          end
        end
        S_CHECK: begin
          if (bad_s) begin
            ctl_next_s.state = S_IDLE;
          end else begin
            ctl_next_s.state = S_WRITE;
          end
        end
        S_WRITE: begin
          ctl_next_s.cnt   = (ctl_r.cnt >= 4'd9) ? 4'd9 : ctl_r.cnt + 4'd1;
          ctl_next_s.state = S_EVAL;
        end
        S_EVAL: begin
          // a win takes priority, so a ninth-move win is never a draw
          if (win_s) begin
            ctl_next_s.status = ctl_r.turn ? ST_O_WIN : ST_X_WIN;
            ctl_next_s.state  = S_DONE;
          end else if (ctl_r.cnt == 4'd9) begin
            ctl_next_s.status = ST_DRAW;
            ctl_next_s.state  = S_DONE;
          end else begin
            ctl_next_s.turn  = ~ctl_r.turn;
            ctl_next_s.state = S_IDLE;
          end
        end
        S_DONE: begin
          ctl_next_s.state = S_DONE;
        end
        default: begin
          ctl_next_s.state = S_IDLE;
        end
      endcase
    end
  end

  // Master stage: holds the value a ph2-transparent latch has when ph2 closes
  always_ff @(negedge ph2) begin
    ctl_mst_r <= ctl_next_s;
  end

  // Slave latch: transparent while ph1 is high, publishing the new state
  always_latch begin
    if (ph1) begin
      ctl_r <= ctl_mst_r;
    end
  end

  // Outputs decode the slave state; reset kills the write strobe at once
  assign moveReady = (ctl_r.state == S_IDLE);
  assign wrEn      = reset & (ctl_r.state == S_WRITE);
  assign addr      = ctl_r.cap_addr;
  assign cellState = player_code(ctl_r.turn);
  assign turn      = ctl_r.turn;
  assign status    = ctl_r.status;
  assign illegal   = reset & (ctl_r.state == S_CHECK) & bad_s;

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: a move-level reference model is compared on every
// cycle, and directed game scenarios pin the model with literal values.
module tb_move_ctrl;

  logic        ph1, ph2, reset, moveValid;
  logic [3:0]  moveAddr;
  logic        moveReady;
  logic [17:0] gBoard;
  logic        wrEn;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic        turn;
  logic [1:0]  status;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  move_ctrl #(.START_PLAYER(1'b0)) dut (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .moveValid(moveValid), .moveAddr(moveAddr), .moveReady(moveReady),
    .gBoard(gBoard), .wrEn(wrEn), .addr(addr), .cellState(cellState),
    .turn(turn), .status(status), .illegal(illegal)
  );

  // Two non-overlapping phases: ph1 high 5-15, ph2 high 20-30, period 40
  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    forever begin
      #5  ph1 = 1'b1;
      #10 ph1 = 1'b0;
      #5  ph2 = 1'b1;
      #10 ph2 = 1'b0;
      #10;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Board memory sharing the controller's reset
  always @(negedge ph2) begin
    if (!reset) gBoard <= '0;
    else if (wrEn && addr < 4'd9) gBoard[addr*2 +: 2] <= cellState;
  end

  // ---------------- reference model (per-move view) ----------------
  int m_age;      // cycles since the current move was accepted, 0 = waiting
  int m_cell, m_turn, m_status, m_moves;
  bit m_over;
  bit m_ok = 1'b0;
  int m_cells[9];

  function automatic bit m_wins(int p);
    bit w;
    w = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (m_cells[3*r] == p && m_cells[3*r+1] == p && m_cells[3*r+2] == p) w = 1'b1;
      if (m_cells[r] == p && m_cells[r+3] == p && m_cells[r+6] == p) w = 1'b1;
    end
    if (m_cells[0] == p && m_cells[4] == p && m_cells[8] == p) w = 1'b1;
    if (m_cells[2] == p && m_cells[4] == p && m_cells[6] == p) w = 1'b1;
    return w;
  endfunction

  // Compare every cycle, then advance the model with this cycle's inputs
  always @(posedge ph2) begin
    int  e_wr, e_ill;
    bit  bad;
    #5;
    bad   = (m_cell > 8) ? 1'b1 : (m_cells[m_cell] != 0);
    e_wr  = int'(reset && m_age == 2 && !m_over);
    e_ill = int'(reset && m_age == 1 && bad);
    if (m_ok) begin
      chk("moveReady", int'(moveReady), int'(m_age == 0 && !m_over));
      chk("wrEn", int'(wrEn), e_wr);
      if (e_wr == 1) begin
        chk("addr", int'(addr), m_cell);
        chk("cellState", int'(cellState), m_turn + 1);
      end
      chk("illegal", int'(illegal), e_ill);
      chk("turn", int'(turn), m_turn);
      chk("status", int'(status), m_status);
    end
    if (!reset) begin
      m_ok = 1'b1; m_age = 0; m_cell = 0; m_turn = 0; m_status = 0;
      m_moves = 0; m_over = 1'b0;
      for (int i = 0; i < 9; i++) m_cells[i] = 0;
    end else if (m_ok && !m_over) begin
      if (m_age == 0) begin
        if (moveValid) begin m_cell = int'(moveAddr); m_age = 1; end
      end else if (m_age == 1) begin
        m_age = bad ? 0 : 2;
      end else if (m_age == 2) begin
        m_cells[m_cell] = m_turn + 1;
        m_moves = (m_moves < 9) ? m_moves + 1 : 9;
        m_age = 3;
      end else begin
        if (m_wins(m_turn + 1)) begin m_status = m_turn + 1; m_over = 1'b1; end
        else if (m_moves == 9) begin m_status = 3; m_over = 1'b1; end
        else begin m_turn = 1 - m_turn; m_age = 0; end
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic cyc(); @(negedge ph1); endtask
  task automatic smp(); @(posedge ph2); #6; endtask

  task automatic do_reset();
    cyc(); reset = 1'b0; moveValid = 1'b0;
    cyc(); cyc(); reset = 1'b1;
    smp();
    chk("rst_moveReady", int'(moveReady), 1);
    chk("rst_status", int'(status), 0);
    chk("rst_turn", int'(turn), 0);
    chk("rst_wrEn", int'(wrEn), 0);
    chk("rst_illegal", int'(illegal), 0);
  endtask

  // Present a move for one cycle while idle; returns in the CHECK cycle
  task automatic issue(input logic [3:0] a);
    int k;
    k = 0;
    cyc();
    while (!moveReady && k < 20) begin cyc(); k++; end
    if (k >= 20) chk("ready_timeout", 0, 1);
    moveValid = 1'b1; moveAddr = a;
    cyc();
    moveValid = 1'b0; moveAddr = 4'($urandom_range(0, 15));
  endtask

  task automatic play(input logic [3:0] a);
    issue(a); cyc(); cyc(); cyc();
  endtask

  logic [3:0] bad_addrs [2];
  logic [3:0] draw_seq [9];

  initial begin
    reset = 1'b0; moveValid = 1'b0; moveAddr = 4'd0;
    bad_addrs = '{4'd9, 4'd15};
    draw_seq  = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

    // First move X to the centre
    do_reset();
    issue(4'd4);
    smp(); chk("c_illegal", int'(illegal), 0);
    cyc(); smp();
    chk("c_wrEn", int'(wrEn), 1);
    chk("c_addr", int'(addr), 4);
    chk("c_cellState", int'(cellState), 1);
    cyc(); cyc(); smp();
    chk("c_turn", int'(turn), 1);

    // O tries the occupied centre
    issue(4'd4);
    smp(); chk("occ_illegal", int'(illegal), 1);
    cyc(); smp();
    chk("occ_wrEn", int'(wrEn), 0);
    chk("occ_turn", int'(turn), 1);

    // Addresses off the board
    foreach (bad_addrs[j]) begin
      issue(bad_addrs[j]);
      smp(); chk("oob_illegal", int'(illegal), 1);
      cyc(); smp(); chk("oob_wrEn", int'(wrEn), 0);
    end

    // X completes the top row
    do_reset();
    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
    smp();
    chk("win_status", int'(status), 1);
    chk("win_ready", int'(moveReady), 0);
    repeat (4) begin
      cyc(); moveValid = 1'b1; moveAddr = 4'd5;
      smp(); chk("done_wrEn", int'(wrEn), 0);
    end
    moveValid = 1'b0;
    chk("done_status", int'(status), 1);

    // Full board, no line
    do_reset();
    foreach (draw_seq[j]) play(draw_seq[j]);
    smp();
    chk("draw_status", int'(status), 3);
    chk("draw_count", int'(dut.ctl_r.cnt), 9);
    chk("draw_ready", int'(moveReady), 0);

    // Reset arriving in the WRITE cycle
    do_reset();
    issue(4'd6);
    cyc(); reset = 1'b0;
    smp(); chk("wr_rst_wrEn", int'(wrEn), 0);
    cyc(); reset = 1'b1;
    smp();
    chk("wr_rst_status", int'(status), 0);
    chk("wr_rst_turn", int'(turn), 0);
    chk("wr_rst_ready", int'(moveReady), 1);
    chk("wr_rst_board", int'(gBoard), 0);

    // Random play checked by the model
    repeat (3000) begin
      cyc();
      reset     = ($urandom_range(0, 59) != 0);
      moveValid = ($urandom_range(0, 9) < 6);
      moveAddr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
    end
    cyc(); moveValid = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
